dmem_byte_lane_seq: RTL



---
 rtl/dmem_byte_lane_seq.sv | 110 +++++++++++
 1 files changed

// File: rtl/dmem_byte_lane_seq.sv
// dmem_byte_lane_seq: byte-lane load/store sequencer for a byte-wide data RAM; optional ALIGN_CHECK_EN enables misalignment suppression
module dmem_byte_lane_seq #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2:0]        num,
    input  logic              we,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] byte_addr,
    input  logic              byte_valid,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [7:0]        ram_wdata,
    input  logic [7:0]        ram_rdata,
    output logic [31:0]       rdata,
    output logic              busy,
    output logic              done,
    output logic              misalign
);
    typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN, FIN} state_t;
    state_t state, state_nx;
    logic [2:0] num_q;
    logic we_q;
    logic [DATA_W-1:0] wdata_q;
    logic [31:0] sh, sh_nx, ext;
    logic [2:0] k, n;
    logic [1:0] c;
    logic pend, beat, last, bad;
    logic [ADDR_W-1:0] addr_q;
    // beat qualification, RAM drive, lane merge and extension
    always_comb begin
        n = (num_q == 3'b001 || num_q == 3'b010) ? 3'd2 :
            (num_q == 3'b011 || num_q == 3'b100) ? 3'd1 : 3'd4;
        beat = state == ACTIVE && byte_valid && k < n && !start;
        last = beat && k == n - 3'd1;
`ifdef ALIGN_CHECK_EN
        bad = beat && k == 3'd0 && ((n == 3'd4 && byte_addr[1:0] != 2'b00) || (n == 3'd2 && byte_addr[0]));
`else
        bad = 1'b0;
`endif
        ram_addr = beat ? byte_addr : addr_q;
        ram_we = beat && we_q && !bad;
        ram_wdata = wdata_q[{k[1:0], 3'b000} +: 8];
        sh_nx = pend ? (sh | (32'(ram_rdata) << {c, 3'b000})) : sh;
        ext = num_q == 3'b001 ? {{16{sh_nx[15]}}, sh_nx[15:0]} :
              num_q == 3'b010 ? {16'h0000, sh_nx[15:0]} :
              num_q == 3'b011 ? {{24{sh_nx[7]}}, sh_nx[7:0]} :
              num_q == 3'b100 ? {24'h000000, sh_nx[7:0]} : sh_nx;
    end
    // next state: start always restarts; stores skip DRAIN; misaligned access ends at first beat
    always_comb begin
        state_nx = start ? ACTIVE :
                   (state == ACTIVE && bad) ? FIN :
                   (state == ACTIVE && last) ? (we_q ? FIN : DRAIN) :
                   state == DRAIN ? FIN :
                   state == FIN ? IDLE : state;
    end
    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= state_nx;
    end
    // access latches, beat/capture counters, load assembly and status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            num_q <= '0;
            we_q <= 1'b0;
            wdata_q <= '0;
            sh <= '0;
            k <= '0;
            c <= '0;
            pend <= 1'b0;
            addr_q <= '0;
            rdata <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            misalign <= 1'b0;
        end else begin
            addr_q <= ram_addr;
            done <= 1'b0;
            misalign <= 1'b0;
            if (start) begin
                num_q <= num;
                we_q <= we;
                wdata_q <= wdata;
                k <= '0;
                c <= '0;
                sh <= '0;
                pend <= 1'b0;
                busy <= 1'b1;
            end else begin
                pend <= beat && !we_q && !bad;
                if (beat) k <= k + 3'd1;
                if (pend) begin
                    sh <= sh_nx;
                    c <= c + 2'd1;
                end
                if ((state == ACTIVE && (bad || (last && we_q))) || state == DRAIN) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                    misalign <= bad;
                end
                if (state == DRAIN) rdata <= ext;
            end
        end
    end
endmodule
